// File: rtl/device_event_sequencer.sv
// Per-device connect/disconnect edge detector with one pending event per device,
// serialised round-robin into a single change/on_off strobe for the device counter.
module device_event_sequencer #(
    parameter int N_DEV = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_active,
    input  logic             stall,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             busy
);

    logic [N_DEV-1:0] r_prev;
    logic [N_DEV-1:0] r_pend;
    logic [N_DEV-1:0] r_dir;
    logic [ID_W-1:0]  r_rr_ptr;

    logic             w_grant_vld;
    logic [ID_W-1:0]  w_grant_idx;
    logic [ID_W-1:0]  w_cand;
    logic [N_DEV-1:0] w_pend_nxt;
    logic [N_DEV-1:0] w_dir_nxt;

    // Scan offsets from far to near so the candidate closest to rr_ptr is kept last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            int s;
            s = int'(r_rr_ptr) + k;
            if (s >= N_DEV) s = s - N_DEV;
            w_cand = ID_W'(s);
            if (!stall && r_pend[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // A reverse edge on a pending, unserviced device cancels it; on a device being
    // serviced this edge it becomes a fresh event.
    always_comb begin
        w_pend_nxt = r_pend;
        w_dir_nxt  = r_dir;
        for (int i = 0; i < N_DEV; i++) begin
            logic serviced;
            serviced = w_grant_vld && (w_grant_idx == ID_W'(i));
            if (serviced) w_pend_nxt[i] = 1'b0;
            if (dev_active[i] != r_prev[i]) begin
                if (!r_pend[i] || serviced) begin
                    w_pend_nxt[i] = 1'b1;
                    w_dir_nxt[i]  = dev_active[i];
                end else begin
                    w_pend_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev   <= '0;
            r_pend   <= '0;
            r_dir    <= '0;
            r_rr_ptr <= '0;
            change   <= 1'b0;
            on_off   <= 1'b0;
            dev_id   <= '0;
            busy     <= 1'b0;
        end else begin
            r_prev <= dev_active;
            r_pend <= w_pend_nxt;
            r_dir  <= w_dir_nxt;
            busy   <= |w_pend_nxt;
            change <= w_grant_vld;
            if (w_grant_vld) begin
                on_off   <= r_dir[w_grant_idx];
                dev_id   <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == ID_W'(N_DEV - 1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_device_event_sequencer.sv
// Directed cycle-by-cycle vector bench for device_event_sequencer (N_DEV=8).
module tb_device_event_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dev_active;
    logic       stall;
    logic       change;
    logic       on_off;
    logic [2:0] dev_id;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    device_event_sequencer #(.N_DEV(8), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .dev_active(dev_active), .stall(stall),
        .change(change), .on_off(on_off), .dev_id(dev_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       stall;
        logic [7:0] da;
        logic       ch;
        logic       oo;
        logic [2:0] id;
        logic       bz;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic [7:0] da,
                       input logic ch, input logic oo, input logic [2:0] id,
                       input logic bz, input string tag);
        vec_t v;
        v.rst = r; v.stall = s; v.da = da;
        v.ch = ch; v.oo = oo; v.id = id; v.bz = bz; v.tag = tag;
        tbl.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic r, input logic s, input logic [7:0] da,
                        input logic ch, input logic oo, input logic [2:0] id,
                        input logic bz, input string tag);
        @(negedge clk);
        rst = r; stall = s; dev_active = da;
        @(posedge clk);
        #1;
        n_vec++;
        if ({change, on_off, dev_id, busy} !== {ch, oo, id, bz}) begin
            n_bad++;
            $display("FAIL %s #%0d: got ch=%b oo=%b id=%0d busy=%b, want ch=%b oo=%b id=%0d busy=%b",
                     tag, n_vec, change, on_off, dev_id, busy, ch, oo, id, bz);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; dev_active = 8'h00;

        // reset held, then quiet
        for (int i = 0; i < 3; i++)  add(1, 0, 8'h00, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 10; i++) add(0, 0, 8'h00, 0, 0, 0, 0, "idle");
        // all connect burst: ids 0..7 back to back
        add(0, 0, 8'hFF, 0, 0, 0, 1, "burst_on_cap");
        for (int i = 0; i < 8; i++) add(0, 0, 8'hFF, 1, 1, 3'(i), (i < 7), "burst_on");
        add(0, 0, 8'hFF, 0, 1, 7, 0, "burst_on_end");
        // all disconnect burst
        add(0, 0, 8'h00, 0, 1, 7, 1, "burst_off_cap");
        for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 1, 0, 3'(i), (i < 7), "burst_off");
        add(0, 0, 8'h00, 0, 0, 7, 0, "burst_off_end");
        // single connect, 2-edge latency
        add(0, 0, 8'h08, 0, 0, 7, 1, "single_cap");
        add(0, 0, 8'h08, 1, 1, 3, 0, "single_evt");
        add(0, 0, 8'h08, 0, 1, 3, 0, "single_end");
        // round robin from rr_ptr=4: dev 6 before dev 1
        add(0, 0, 8'h4A, 0, 1, 3, 1, "rr_cap");
        add(0, 0, 8'h4A, 1, 1, 6, 1, "rr_first");
        add(0, 0, 8'h4A, 1, 1, 1, 0, "rr_second");
        add(0, 0, 8'h4A, 0, 1, 1, 0, "rr_end");
        // glitch under stall cancels
        add(0, 1, 8'h6A, 0, 1, 1, 1, "glitch_rise");
        add(0, 1, 8'h4A, 0, 1, 1, 0, "glitch_cancel");
        add(0, 0, 8'h4A, 0, 1, 1, 0, "glitch_nopulse");
        add(0, 0, 8'h4A, 0, 1, 1, 0, "glitch_nopulse");
        // stall retains a pending event; scan wraps 2..7,0
        add(0, 1, 8'h4B, 0, 1, 1, 1, "stall_cap");
        add(0, 1, 8'h4B, 0, 1, 1, 1, "stall_hold");
        add(0, 0, 8'h4B, 1, 1, 0, 0, "stall_release");
        add(0, 0, 8'h4B, 0, 1, 0, 0, "stall_end");
        // reset mid-operation drops pending events; re-emitted after release
        add(1, 0, 8'h00, 0, 0, 0, 0, "rst_clear");
        add(0, 0, 8'h3C, 0, 0, 0, 1, "mid_cap");
        add(0, 1, 8'h3C, 0, 0, 0, 1, "mid_stall");
        add(1, 1, 8'h3C, 0, 0, 0, 0, "mid_rst");
        add(1, 1, 8'h3C, 0, 0, 0, 0, "mid_rst");
        add(0, 0, 8'h3C, 0, 0, 0, 1, "mid_recap");
        add(0, 0, 8'h3C, 1, 1, 2, 1, "mid_evt");
        add(0, 0, 8'h3C, 1, 1, 3, 1, "mid_evt");
        add(0, 0, 8'h3C, 1, 1, 4, 1, "mid_evt");
        add(0, 0, 8'h3C, 1, 1, 5, 0, "mid_evt");
        add(0, 0, 8'h3C, 0, 1, 5, 0, "mid_end");

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].stall, tbl[i].da, tbl[i].ch, tbl[i].oo,
                 tbl[i].id, tbl[i].bz, tbl[i].tag);

        // Hand sequence: dev 0 falls on the very edge its connect is serviced
        // (rr_ptr=6, scan 6,7,0); the disconnect must follow as its own event.
        step(0, 0, 8'h3D, 0, 1, 5, 1, "new_wins_cap");
        step(0, 0, 8'h3C, 1, 1, 0, 1, "new_wins_svc");
        step(0, 0, 8'h3C, 1, 0, 0, 0, "new_wins_evt");
        step(0, 0, 8'h3C, 0, 0, 0, 0, "new_wins_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/device_event_sequencer.md
Name: device_event_sequencer

Overview:
- Upstream front-end for the active IoT devices counter.
- Watches N_DEV per-device activity levels and detects connect (0->1) and disconnect (1->0) transitions.
- Queues one pending event per device and serialises the events, one per clock, into a single change/on_off pulse stream that drives the counter's change and on_off inputs.
- Uses a round-robin arbiter so that no device is starved when several devices change state together.

Parameters:
- N_DEV, 8, number of monitored devices (2..256).
- ID_W, 3, width of dev_id; 2**ID_W >= N_DEV is required.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- dev_active  in  N_DEV  per-device activity level, already synchronised to clk; 1 = device active.
- stall  in  1  downstream hold; 1 = do not emit an event this cycle.
- change  out  1  registered one-cycle event strobe; connects to the counter's change input.
- on_off  out  1  event direction (1 = connect, 0 = disconnect); valid when change=1.
- dev_id  out  ID_W  index of the device that produced the event; valid when change=1.
- busy  out  1  registered; 1 while any event is pending.

Behaviour:
- State:
  - dev_prev[N_DEV]: last sampled level.
  - pend[N_DEV]: event pending.
  - dir[N_DEV]: pending direction.
  - rr_ptr[ID_W]: round-robin start index.
- Reset (rst=1 at an edge):
  - dev_prev, pend, dir, rr_ptr <= 0.
  - change, on_off, dev_id, busy <= 0.
  - rst takes priority over every other input and clears any reset mid-operation, including pending events.
- After reset, all devices are treated as inactive. Any device with dev_active=1 when rst deasserts produces a connect event.
- Edge detect, every edge with rst=0:
  - dev_prev <= dev_active.
  - For each i where dev_active[i] != dev_prev[i]:
    - if pend[i]=0: pend[i] <= 1, dir[i] <= dev_active[i].
    - if pend[i]=1 and device i is not being serviced this edge: pend[i] <= 0 (the opposite edge cancels; net zero change, no event).
    - if pend[i]=1 and device i is being serviced this edge: the new edge wins, so pend[i] <= 1 and dir[i] <= dev_active[i].
- Arbitration, same edge, using pend before update:
  - If stall=0 and any pend bit is set, select the first i scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_DEV.
  - Then: change <= 1, on_off <= dir[i], dev_id <= i, pend[i] cleared (subject to the new-edge-wins rule), rr_ptr <= (i+1) mod N_DEV.
  - Otherwise change <= 0, and on_off, dev_id and rr_ptr hold their values.
- stall=1:
  - No event is emitted.
  - Pending events are retained; new edges are still captured and cancelled as above.
  - change falls to 0 on the next edge.
- busy <= OR of the next-state pend bits.
- Latency:
  - A dev_active change first sampled at edge E0 sets pend at E0.
  - change=1 is visible from E1 to E2, provided stall=0 and there is no contention.
  - Minimum latency is 2 edges from the input change to the strobe.
- Throughput:
  - Sustained rate is 1 event/cycle.
  - A burst of k simultaneous edges drains in k unstalled cycles.
- change is never high for a device whose pending event has been cancelled.
- At most one event per device is ever outstanding, so events are never dropped or lost.

Test Plan:
1. Hold rst=1 for 3 cycles with dev_active=8'h00, then release -> change, on_off, dev_id, busy all 0 for the following 10 cycles.
2. Set dev_active[3]=1 before edge E0 -> busy=1 after E0; change=1, on_off=1, dev_id=3 for exactly the cycle E1-E2; busy=0 after E1.
3. From all-zero, set dev_active=8'hFF at E0 -> 8 consecutive change pulses with dev_id 0,1,...,7 and on_off=1, no gaps; busy=0 after the 8th.
4. With stall=1, pulse dev_active[5] high for 1 cycle (rise, then fall one edge later) -> pend[5] set then cancelled, busy drops; release stall -> no change pulse.
5. Round-robin check: rr_ptr=4 (after servicing dev 3); raise devs 1 and 6 together -> events emitted in order dev_id=6 then dev_id=1.
6. Reset mid-operation: raise 4 devices, assert stall, then assert rst -> all outputs 0. Release rst and stall with dev_active unchanged -> 4 connect events are re-emitted.
